// File: rtl/spi_regbank.sv
// SPI mode-0 slave register bank. Pins are oversampled on clk. Frames are {rw, addr, data}, MSB first.
// Good writes commit with a per-register strobe. Reads shift out on sdo. Bad frames pulse frame_err.

module spi_regbank_cell #(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              strobe
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q      <= RESET_VAL;
      strobe <= 1'b0;
    end else begin
      strobe <= we;
      if (we) q <= d;
    end
  end
endmodule

module spi_regbank #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 7,
  parameter int NUM_REGS  = 5,
  parameter int RESET_VAL = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       sdi,
  input  logic                       cs_n,
  output logic                       sdo,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err
);
  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam int SH_W    = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, DONE} state_t;
  state_t state_q, state_d;

  logic sclk_s1, sclk_s2, sclk_s3, cs_s1, cs_s2, cs_s3, sdi_s1, sdi_s2;
  logic rise_sclk, fall_sclk, rise_cs, sclk_step, addr_end, frame_ok, rw_q;
  logic [CNT_W-1:0]    cnt_q, cnt_inc;
  logic [SH_W-1:0]     shreg_q, sh_nx;
  logic [DATA_W-1:0]   osh_q, rd_val;
  logic [ADDR_W-1:0]   addr_q;
  logic [NUM_REGS-1:0] we;
  logic [DATA_W-1:0]   reg_q [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {sclk_s1, sclk_s2, sclk_s3} <= 3'b000;
      {cs_s1, cs_s2, cs_s3}       <= 3'b111;
      {sdi_s1, sdi_s2}            <= 2'b00;
    end else begin
      {sclk_s1, sclk_s2, sclk_s3} <= {sclk, sclk_s1, sclk_s2};
      {cs_s1, cs_s2, cs_s3}       <= {cs_n, cs_s1, cs_s2};
      {sdi_s1, sdi_s2}            <= {sdi, sdi_s1};
    end
  end

  assign rise_sclk = sclk_s2 & ~sclk_s3;
  assign fall_sclk = ~sclk_s2 & sclk_s3;
  assign rise_cs   = cs_s2 & ~cs_s3;
  // An sclk edge that coincides with the end of the frame is not counted.
  assign sclk_step = rise_sclk & ~rise_cs;
  assign cnt_inc   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
  assign sh_nx     = {shreg_q[SH_W-2:0], sdi_s2};
  assign addr_end  = (state_q == ADDR) && sclk_step && (cnt_q == CNT_ADDR);
  assign frame_ok  = (cnt_q == CNT_FULL) && (int'(addr_q) < NUM_REGS);

  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (int'(sh_nx[ADDR_W-1:0]) == k) rd_val = reg_q[k];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      // Level test, so a falling edge that arrives while in DONE is still taken here.
      IDLE:  if (!cs_s2) state_d = ADDR;
      ADDR:  if (rise_cs) state_d = DONE;
             else if (addr_end) state_d = sh_nx[ADDR_W] ? WDATA : RDATA;
      WDATA, RDATA: if (rise_cs) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      osh_q     <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      sdo       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_err <= (state_q == DONE) && (cnt_q != '0) && !frame_ok;
      if (state_q != RDATA) sdo <= 1'b0;
      case (state_q)
        IDLE: if (!cs_s2) begin
          cnt_q   <= '0;
          shreg_q <= '0;
          addr_q  <= '0;
          rw_q    <= 1'b0;
        end
        ADDR, WDATA: if (sclk_step) begin
          cnt_q   <= cnt_inc;
          shreg_q <= sh_nx;
        end
        RDATA: begin
          if (sclk_step) cnt_q <= cnt_inc;
          if (fall_sclk && !rise_cs) begin
            sdo   <= osh_q[DATA_W-1];
            osh_q <= osh_q << 1;
          end
        end
        default: ;
      endcase
      if (addr_end) begin
        addr_q <= sh_nx[ADDR_W-1:0];
        rw_q   <= sh_nx[ADDR_W];
        osh_q  <= rd_val;
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    assign we[k] = (state_q == DONE) && frame_ok && rw_q && (int'(addr_q) == k);
    spi_regbank_cell #(.DATA_W(DATA_W), .RESET_VAL(DATA_W'(RESET_VAL))) u_cell (
      .clk    (clk),
      .rst    (rst),
      .we     (we[k]),
      .d      (shreg_q[DATA_W-1:0]),
      .q      (reg_q[k]),
      .strobe (wr_strobe[k])
    );
    assign regs[k*DATA_W +: DATA_W] = reg_q[k];
  end
endmodule

// File: tb/tb_spi_regbank.sv
// Scoreboard bench for spi_regbank: an SPI host task issues frames and queues expected events.
// A monitor pops and compares wr_strobe/frame_err pulses, register contents and read-back data.

module tb_spi_regbank;
  localparam int DW = 8, AW = 7, NR = 5, FW = 1 + AW + DW;

  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, sdi = 1'b0, cs_n = 1'b1;
  logic sdo, frame_err;
  logic [NR*DW-1:0] regs;
  logic [NR-1:0]    wr_strobe;

  spi_regbank #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .RESET_VAL(0)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .sdi(sdi), .cs_n(cs_n),
    .sdo(sdo), .regs(regs), .wr_strobe(wr_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {bit is_err; int addr; logic [DW-1:0] data;} ev_t;
  typedef struct {logic [31:0] bits; logic idle;} rd_t;

  ev_t          exp_q[$];
  logic [31:0]  rdexp_q[$];
  rd_t          rdgot_q[$];
  logic [DW-1:0] mdl [NR];
  logic [NR*DW-1:0] shadow = '0;
  int total = 0, bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Host: n bits of {rw, addr, data} MSB first (extra random bits past FW); abort_at>=0 leaves cs_n low.
  task automatic frame(input bit rw, input int addr, input logic [DW-1:0] data,
                       input int n, input int gap, input int abort_at);
    logic [FW-1:0] f;
    logic [31:0] bits, got, expb;
    logic idle;
    bit valid;
    ev_t e;
    rd_t r;
    f = {rw, AW'(addr), data};
    if (n <= FW) bits = 32'(f) >> (FW - n);
    else         bits = (32'(f) << (n - FW)) | 32'($urandom_range(0, (1 << (n - FW)) - 1));
    valid = (n == FW) && (addr < NR);
    expb  = '0;
    if (!rw && n == FW && addr < NR) expb = 32'(mdl[addr]);
    got = '0;
    @(negedge clk);
    idle = sdo;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) return;
      sdi = bits[n-1-i];
      repeat (4) @(negedge clk);
      got[n-1-i] = sdo;
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    if (n != 0) begin
      if (valid && rw) begin
        e.is_err = 1'b0; e.addr = addr; e.data = data;
        exp_q.push_back(e);
        mdl[addr] = data;
      end else if (!valid) begin
        e.is_err = 1'b1; e.addr = addr; e.data = '0;
        exp_q.push_back(e);
      end
    end
    r.bits = got;
    r.idle = idle;
    rdexp_q.push_back(expb);
    rdgot_q.push_back(r);
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; sdi = 1'b0;
    for (int k = 0; k < NR; k++) mdl[k] = '0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin : monitor
    ev_t e;
    rd_t g;
    logic [31:0] x;
    forever begin
      @(negedge clk);
      if (rst) shadow = '0;
      else if (wr_strobe != '0 || frame_err) begin
        if (exp_q.size() == 0) check("event", 64'({frame_err, wr_strobe}), 64'(0));
        else begin
          e = exp_q.pop_front();
          if (e.is_err) check("frame_err", 64'({frame_err, wr_strobe}), 64'({1'b1, NR'(0)}));
          else begin
            check("wr_strobe", 64'({frame_err, wr_strobe}), 64'({1'b0, NR'(1) << e.addr}));
            shadow[e.addr*DW +: DW] = e.data;
          end
        end
      end
      check("regs", 64'(regs), 64'(shadow));
      if (rdgot_q.size() > 0 && rdexp_q.size() > 0) begin
        g = rdgot_q.pop_front();
        x = rdexp_q.pop_front();
        check("sdo_idle", 64'(g.idle), 64'(0));
        check("sdo_bits", 64'(g.bits), 64'(x));
      end
    end
  end

  initial begin : stim
    bit rw;
    int addr, n, gap;
    logic [DW-1:0] d;
    for (int k = 0; k < NR; k++) mdl[k] = '0;
    repeat (3) @(negedge clk);
    check("rst_regs", 64'(regs), 64'(0));
    check("rst_sdo", 64'(sdo), 64'(0));
    check("rst_strobe", 64'(wr_strobe), 64'(0));
    check("rst_err", 64'(frame_err), 64'(0));
    rst = 1'b0;
    repeat (3) @(negedge clk);

    frame(1'b1, 2, 8'hA5, FW, 6, -1);
    check("reg2_a5", 64'(regs[2*DW +: DW]), 64'(8'hA5));
    frame(1'b0, 2, 8'h00, FW, 6, -1);
    frame(1'b1, 5, 8'hFF, FW, 6, -1);
    frame(1'b0, 6, 8'h00, FW, 6, -1);
    frame(1'b1, 3, 8'hC0, 12, 6, -1);
    frame(1'b1, 3, 8'h55, FW + 1, 6, -1);
    frame(1'b0, 0, 8'h00, 0, 6, -1);
    frame(1'b1, 0, 8'h11, FW, 3, -1);
    frame(1'b1, 4, 8'h22, FW, 6, -1);
    check("reg0_11", 64'(regs[0 +: DW]), 64'(8'h11));
    check("reg4_22", 64'(regs[4*DW +: DW]), 64'(8'h22));

    frame(1'b1, 1, 8'h99, FW, 0, 10);
    do_reset();
    check("abort_regs", 64'(regs), 64'(0));
    check("abort_strobe", 64'(wr_strobe), 64'(0));
    frame(1'b1, 1, 8'h77, FW, 6, -1);
    check("reg1_77", 64'(regs[DW +: DW]), 64'(8'h77));

    repeat (40) begin
      rw   = 1'($urandom_range(0, 1));
      addr = $urandom_range(0, 7);
      d    = DW'($urandom);
      n    = FW;
      if (rw && $urandom_range(0, 4) == 0) n = ($urandom_range(0, 1) == 0) ? FW - 1 : FW + 1;
      gap  = $urandom_range(3, 8);
      frame(rw, addr, d, n, gap, -1);
    end

    repeat (20) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    check("rd_q_drained", 64'(rdgot_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
